// File: rtl/memory_access_stage.sv
// rtl/memory_access_stage.sv - RV32I MEM stage: dmem req/ready access, byte lanes, load extend, stall (option: DMEM_MISALIGN_CHECK_EN)
module memory_access_stage #(
   parameter int TIMEOUT_CYCLES = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        memRead_Mem_In,
   input  logic        memWrite_Mem_In,
   input  logic [2:0]  funct3_Mem_In,
   input  logic [31:0] aluOut_Mem_In,
   input  logic [31:0] writeData_Mem_In,
   input  logic        regWrite_Mem_In,
   input  logic        memToRegWrite_Mem_In,
   input  logic [4:0]  rd_Mem_In,
   output logic        dmem_req,
   output logic        dmem_we,
   output logic [31:0] dmem_addr,
   output logic [31:0] dmem_wdata,
   output logic [3:0]  dmem_be,
   input  logic        dmem_ready,
   input  logic [31:0] dmem_rdata,
   output logic [31:0] readD_Mem_Out,
   output logic [31:0] aluOut_Mem_Out,
   output logic [4:0]  rd_Mem_Out,
   output logic        memToRegWrite_Mem_Out,
   output logic        regWrite_Mem_Out,
   output logic        stall_Mem,
   output logic        busErr_Mem,
   output logic        misaligned_Mem
);

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

   state_t      r_state;
   logic [7:0]  r_cnt;
   logic [31:0] r_addr;
   logic [31:0] r_wdata;
   logic [3:0]  r_be;
   logic        r_we;
   logic [2:0]  r_funct3;
   logic [1:0]  r_off;
   logic [31:0] r_read_data;
   logic        r_bus_err;

   logic        w_access;
   logic        w_is_byte;
   logic        w_is_half;
   logic [1:0]  w_off;
   logic        w_misaligned;
   logic        w_issue;
   logic [3:0]  w_be;
   logic [31:0] w_wdata;
   logic [31:0] w_shifted;
   logic [31:0] w_load_data;

   assign w_access  = memRead_Mem_In | memWrite_Mem_In;
   assign w_is_byte = (funct3_Mem_In[1:0] == 2'b00);
   assign w_is_half = (funct3_Mem_In[1:0] == 2'b01);

   // Lane offset with the low bits masked to the access size; words always start at lane 0
   assign w_off = w_is_byte ? aluOut_Mem_In[1:0] :
                  w_is_half ? {aluOut_Mem_In[1], 1'b0} : 2'b00;

`ifdef DMEM_MISALIGN_CHECK_EN
   logic r_misaligned;
   assign w_misaligned = w_access &
                         ((w_is_half & aluOut_Mem_In[0]) |
                          (!w_is_byte && !w_is_half && (aluOut_Mem_In[1:0] != 2'b00)));
   assign misaligned_Mem = r_misaligned;
`else
   assign w_misaligned   = 1'b0;
   assign misaligned_Mem = 1'b0;
`endif

   assign w_issue = (r_state == S_IDLE) & w_access & ~w_misaligned;

   // Byte enables and lane-replicated store data for the incoming request
   always_comb begin
      w_be    = 4'b1111;
      w_wdata = writeData_Mem_In;
      if (w_is_byte) begin
         w_wdata = {4{writeData_Mem_In[7:0]}};
         if (memWrite_Mem_In) w_be = 4'b0001 << w_off;
      end else if (w_is_half) begin
         w_wdata = {2{writeData_Mem_In[15:0]}};
         if (memWrite_Mem_In) w_be = w_off[1] ? 4'b1100 : 4'b0011;
      end
   end

   // Align the returned word to the captured lane and extend per the captured funct3
   assign w_shifted = dmem_rdata >> {r_off, 3'b000};
   always_comb begin
      w_load_data = dmem_rdata;
      case (r_funct3)
         3'b000:  w_load_data = {{24{w_shifted[7]}}, w_shifted[7:0]};
         3'b100:  w_load_data = {24'h0, w_shifted[7:0]};
         3'b001:  w_load_data = {{16{w_shifted[15]}}, w_shifted[15:0]};
         3'b101:  w_load_data = {16'h0, w_shifted[15:0]};
         default: w_load_data = dmem_rdata;
      endcase
   end

   // Request goes out combinationally on issue, then is held from the registers while waiting
   assign dmem_req   = w_issue | (r_state == S_WAIT);
   assign dmem_addr  = w_issue ? {aluOut_Mem_In[31:2], 2'b00} : r_addr;
   assign dmem_we    = w_issue ? memWrite_Mem_In : r_we;
   assign dmem_be    = w_issue ? w_be : r_be;
   assign dmem_wdata = w_issue ? w_wdata : r_wdata;

   assign stall_Mem             = ((r_state == S_IDLE) & w_access) | (r_state == S_WAIT);
   assign busErr_Mem            = r_bus_err;
   assign readD_Mem_Out         = r_read_data;
   assign aluOut_Mem_Out        = aluOut_Mem_In;
   assign rd_Mem_Out            = rd_Mem_In;
   assign memToRegWrite_Mem_Out = memToRegWrite_Mem_In;
   assign regWrite_Mem_Out      = regWrite_Mem_In & ~(busErr_Mem | misaligned_Mem);

   // Access FSM: IDLE issues, WAIT holds until ready or timeout, DONE lets MEM/WB capture once
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= S_IDLE;
         r_cnt       <= 8'd0;
         r_addr      <= 32'd0;
         r_wdata     <= 32'd0;
         r_be        <= 4'd0;
         r_we        <= 1'b0;
         r_funct3    <= 3'd0;
         r_off       <= 2'd0;
         r_read_data <= 32'd0;
         r_bus_err   <= 1'b0;
`ifdef DMEM_MISALIGN_CHECK_EN
         r_misaligned <= 1'b0;
`endif
      end else begin
         r_bus_err <= 1'b0;
`ifdef DMEM_MISALIGN_CHECK_EN
         r_misaligned <= 1'b0;
`endif
         case (r_state)
            S_IDLE: begin
               if (w_access) begin
`ifdef DMEM_MISALIGN_CHECK_EN
                  if (w_misaligned) begin
                     r_misaligned <= 1'b1;
                     r_read_data  <= 32'd0;
                     r_state      <= S_DONE;
                  end else
`endif
                  begin
                     r_addr   <= {aluOut_Mem_In[31:2], 2'b00};
                     r_we     <= memWrite_Mem_In;
                     r_be     <= w_be;
                     r_wdata  <= w_wdata;
                     r_funct3 <= funct3_Mem_In;
                     r_off    <= w_off;
                     r_cnt    <= 8'd0;
                     r_state  <= S_WAIT;
                  end
               end
            end
            S_WAIT: begin
               if (dmem_ready) begin
                  r_read_data <= r_we ? 32'd0 : w_load_data;
                  r_state     <= S_DONE;
               end else if (r_cnt == 8'(TIMEOUT_CYCLES - 1)) begin
                  r_read_data <= 32'd0;
                  r_bus_err   <= 1'b1;
                  r_state     <= S_DONE;
               end else begin
                  r_cnt <= r_cnt + 8'd1;
               end
            end
            S_DONE:  r_state <= S_IDLE;
            default: r_state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_memory_access_stage.sv
// tb/tb_memory_access_stage.sv - directed bench for memory_access_stage
module tb_memory_access_stage;

   logic        clk = 1'b0;
   logic        rst;
   logic        memRead_Mem_In, memWrite_Mem_In;
   logic [2:0]  funct3_Mem_In;
   logic [31:0] aluOut_Mem_In, writeData_Mem_In;
   logic        regWrite_Mem_In, memToRegWrite_Mem_In;
   logic [4:0]  rd_Mem_In;
   logic        dmem_req, dmem_we;
   logic [31:0] dmem_addr, dmem_wdata;
   logic [3:0]  dmem_be;
   logic        dmem_ready;
   logic [31:0] dmem_rdata;
   logic [31:0] readD_Mem_Out, aluOut_Mem_Out;
   logic [4:0]  rd_Mem_Out;
   logic        memToRegWrite_Mem_Out, regWrite_Mem_Out;
   logic        stall_Mem, busErr_Mem, misaligned_Mem;

   int checks = 0;
   int errors = 0;

   // Observations of one access, filled in by do_access
   int          o_stall, o_req;
   logic        o_done, o_unstable;
   logic [31:0] o_addr, o_wdata, o_readd;
   logic [3:0]  o_be;
   logic        o_we, o_berr, o_mis, o_regw;

   memory_access_stage #(.TIMEOUT_CYCLES(16)) dut (
      .clk(clk), .rst(rst),
      .memRead_Mem_In(memRead_Mem_In), .memWrite_Mem_In(memWrite_Mem_In),
      .funct3_Mem_In(funct3_Mem_In), .aluOut_Mem_In(aluOut_Mem_In),
      .writeData_Mem_In(writeData_Mem_In), .regWrite_Mem_In(regWrite_Mem_In),
      .memToRegWrite_Mem_In(memToRegWrite_Mem_In), .rd_Mem_In(rd_Mem_In),
      .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
      .dmem_wdata(dmem_wdata), .dmem_be(dmem_be), .dmem_ready(dmem_ready),
      .dmem_rdata(dmem_rdata), .readD_Mem_Out(readD_Mem_Out),
      .aluOut_Mem_Out(aluOut_Mem_Out), .rd_Mem_Out(rd_Mem_Out),
      .memToRegWrite_Mem_Out(memToRegWrite_Mem_Out), .regWrite_Mem_Out(regWrite_Mem_Out),
      .stall_Mem(stall_Mem), .busErr_Mem(busErr_Mem), .misaligned_Mem(misaligned_Mem)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_idle();
      memRead_Mem_In       = 1'b0;
      memWrite_Mem_In      = 1'b0;
      funct3_Mem_In        = 3'b000;
      aluOut_Mem_In        = 32'h0;
      writeData_Mem_In     = 32'h0;
      regWrite_Mem_In      = 1'b0;
      memToRegWrite_Mem_In = 1'b0;
      rd_Mem_In            = 5'd0;
      dmem_ready           = 1'b0;
      dmem_rdata           = 32'h0;
   endtask

   task automatic set_op(input logic rd_en, input logic wr_en, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] wd);
      memRead_Mem_In       = rd_en;
      memWrite_Mem_In      = wr_en;
      funct3_Mem_In        = f3;
      aluOut_Mem_In        = addr;
      writeData_Mem_In     = wd;
      regWrite_Mem_In      = rd_en;
      memToRegWrite_Mem_In = rd_en;
      rd_Mem_In            = 5'd5;
   endtask

   // Runs the presented access to DONE, answering ready at cycle ready_at (-1 = never)
   task automatic do_access(input int ready_at, input logic [31:0] rdata);
      o_stall = 0; o_req = 0; o_done = 1'b0; o_unstable = 1'b0;
      o_addr = 32'h0; o_wdata = 32'h0; o_be = 4'h0; o_we = 1'b0;
      o_berr = 1'b0; o_mis = 1'b0; o_regw = 1'b0; o_readd = 32'h0;
      for (int k = 0; k < 40; k++) begin
         dmem_ready = (k == ready_at);
         dmem_rdata = (k == ready_at) ? rdata : 32'h0;
         @(negedge clk);
         if (stall_Mem) o_stall++;
         if (dmem_req) begin
            if (o_req == 0) begin
               o_addr = dmem_addr; o_wdata = dmem_wdata; o_be = dmem_be; o_we = dmem_we;
            end else if (dmem_addr !== o_addr || dmem_wdata !== o_wdata ||
                         dmem_be !== o_be || dmem_we !== o_we) begin
               o_unstable = 1'b1;
            end
            o_req++;
         end
         if (!stall_Mem) begin
            o_done  = 1'b1;
            o_berr  = busErr_Mem;
            o_mis   = misaligned_Mem;
            o_regw  = regWrite_Mem_Out;
            o_readd = readD_Mem_Out;
            step();
            set_idle();
            break;
         end
         step();
      end
      checks++;
      if (!o_done) begin
         errors++;
         $display("FAIL access_done: stall never dropped within 40 cycles");
         set_idle();
      end
   endtask

   task automatic test_reset();
      set_idle();
      rst = 1'b1;
      step(); step();
      rst = 1'b0;
      @(negedge clk);
      checks++; if ({dmem_req, dmem_we, stall_Mem, busErr_Mem, misaligned_Mem} !== 5'b0) begin
         errors++; $display("FAIL reset_flags: got %b expected 00000",
                             {dmem_req, dmem_we, stall_Mem, busErr_Mem, misaligned_Mem}); end
      checks++; if (dmem_addr !== 32'h0 || dmem_wdata !== 32'h0 || dmem_be !== 4'h0) begin
         errors++; $display("FAIL reset_bus: got addr %h wdata %h be %b expected 0",
                             dmem_addr, dmem_wdata, dmem_be); end
      checks++; if (readD_Mem_Out !== 32'h0) begin
         errors++; $display("FAIL reset_readD: got %h expected 00000000", readD_Mem_Out); end
      step();
   endtask

   task automatic test_lb();
      set_op(1'b1, 1'b0, 3'b000, 32'h0000_0103, 32'h0);
      do_access(1, 32'h80AA_BBCC);
      checks++; if (o_addr !== 32'h0000_0100 || o_be !== 4'b1111 || o_we !== 1'b0) begin
         errors++; $display("FAIL lb_bus: got addr %h be %b we %b expected 00000100 1111 0",
                             o_addr, o_be, o_we); end
      checks++; if (o_readd !== 32'hFFFF_FF80) begin
         errors++; $display("FAIL lb_readD: got %h expected ffffff80", o_readd); end
      checks++; if (o_stall !== 2) begin
         errors++; $display("FAIL lb_stall: got %0d expected 2", o_stall); end
   endtask

   task automatic test_passthrough();
      set_idle();
      aluOut_Mem_In = 32'h1234_5678; rd_Mem_In = 5'd7;
      regWrite_Mem_In = 1'b1; memToRegWrite_Mem_In = 1'b0;
      @(negedge clk);
      checks++; if (stall_Mem !== 1'b0 || dmem_req !== 1'b0) begin
         errors++; $display("FAIL pass_stall: got stall %b req %b expected 0 0", stall_Mem, dmem_req); end
      checks++; if (aluOut_Mem_Out !== 32'h1234_5678 || rd_Mem_Out !== 5'd7 ||
                    regWrite_Mem_Out !== 1'b1 || memToRegWrite_Mem_Out !== 1'b0) begin
         errors++; $display("FAIL pass_fields: got %h %0d %b %b expected 12345678 7 1 0",
                             aluOut_Mem_Out, rd_Mem_Out, regWrite_Mem_Out, memToRegWrite_Mem_Out); end
      checks++; if (readD_Mem_Out !== 32'hFFFF_FF80) begin
         errors++; $display("FAIL pass_readD_hold: got %h expected ffffff80", readD_Mem_Out); end
      step();
      set_idle();
   endtask

   task automatic test_stores();
      set_op(1'b0, 1'b1, 3'b001, 32'h0000_0022, 32'h1234_ABCD);
      regWrite_Mem_In = 1'b1;
      do_access(1, 32'h5555_5555);
      checks++; if (o_be !== 4'b1100 || o_wdata !== 32'hABCD_ABCD || o_we !== 1'b1 ||
                    o_addr !== 32'h0000_0020) begin
         errors++; $display("FAIL sh_bus: got be %b wdata %h we %b addr %h expected 1100 abcdabcd 1 00000020",
                             o_be, o_wdata, o_we, o_addr); end
      checks++; if (o_regw !== 1'b1 || o_readd !== 32'h0) begin
         errors++; $display("FAIL sh_done: got regw %b readD %h expected 1 00000000", o_regw, o_readd); end
      set_op(1'b0, 1'b1, 3'b000, 32'h0000_0101, 32'h1234_565A);
      do_access(1, 32'h0);
      checks++; if (o_be !== 4'b0010 || o_wdata !== 32'h5A5A_5A5A) begin
         errors++; $display("FAIL sb_bus: got be %b wdata %h expected 0010 5a5a5a5a", o_be, o_wdata); end
   endtask

   task automatic test_lhu_delay();
      set_op(1'b1, 1'b0, 3'b101, 32'h0000_0002, 32'h0);
      do_access(4, 32'hF00D_0000);
      checks++; if (o_req !== 5 || o_unstable !== 1'b0) begin
         errors++; $display("FAIL lhu_req: got %0d cycles unstable %b expected 5 0", o_req, o_unstable); end
      checks++; if (o_stall !== 5) begin
         errors++; $display("FAIL lhu_stall: got %0d expected 5", o_stall); end
      checks++; if (o_readd !== 32'h0000_F00D) begin
         errors++; $display("FAIL lhu_readD: got %h expected 0000f00d", o_readd); end
      set_op(1'b1, 1'b0, 3'b001, 32'h0000_0002, 32'h0);
      do_access(2, 32'h8001_1234);
      checks++; if (o_readd !== 32'hFFFF_8001) begin
         errors++; $display("FAIL lh_readD: got %h expected ffff8001", o_readd); end
   endtask

   task automatic test_timeout();
      set_op(1'b1, 1'b0, 3'b010, 32'h0000_0010, 32'h0);
      do_access(-1, 32'h0);
      checks++; if (o_stall !== 17) begin
         errors++; $display("FAIL to_stall: got %0d expected 17", o_stall); end
      checks++; if (o_berr !== 1'b1 || o_readd !== 32'h0 || o_regw !== 1'b0) begin
         errors++; $display("FAIL to_done: got berr %b readD %h regw %b expected 1 00000000 0",
                             o_berr, o_readd, o_regw); end
      @(negedge clk);
      checks++; if (busErr_Mem !== 1'b0) begin
         errors++; $display("FAIL to_pulse: got %b expected 0 after DONE", busErr_Mem); end
      step();
   endtask

   task automatic test_misaligned();
      set_op(1'b1, 1'b0, 3'b010, 32'h0000_0008, 32'h0);
      do_access(1, 32'h1111_2222);
      checks++; if (o_readd !== 32'h1111_2222) begin
         errors++; $display("FAIL lw_readD: got %h expected 11112222", o_readd); end
      set_op(1'b1, 1'b0, 3'b010, 32'h0000_0006, 32'h0);
`ifdef DMEM_MISALIGN_CHECK_EN
      do_access(1, 32'hCAFE_BABE);
      checks++; if (o_req !== 0 || o_stall !== 1) begin
         errors++; $display("FAIL mis_req: got req %0d stall %0d expected 0 1", o_req, o_stall); end
      checks++; if (o_mis !== 1'b1 || o_regw !== 1'b0 || o_readd !== 32'h0) begin
         errors++; $display("FAIL mis_done: got mis %b regw %b readD %h expected 1 0 00000000",
                             o_mis, o_regw, o_readd); end
`else
      do_access(1, 32'hCAFE_BABE);
      checks++; if (o_addr !== 32'h0000_0004 || o_stall !== 2) begin
         errors++; $display("FAIL mis_masked: got addr %h stall %0d expected 00000004 2", o_addr, o_stall); end
      checks++; if (o_mis !== 1'b0 || o_regw !== 1'b1 || o_readd !== 32'hCAFE_BABE) begin
         errors++; $display("FAIL mis_load: got mis %b regw %b readD %h expected 0 1 cafebabe",
                             o_mis, o_regw, o_readd); end
`endif
   endtask

   task automatic test_reset_in_wait();
      set_op(1'b1, 1'b0, 3'b010, 32'h0000_0040, 32'h0);
      step();
      @(negedge clk);
      checks++; if (dmem_req !== 1'b1 || stall_Mem !== 1'b1) begin
         errors++; $display("FAIL rw_wait: got req %b stall %b expected 1 1", dmem_req, stall_Mem); end
      step();
      rst = 1'b1;
      set_idle();
      step();
      rst = 1'b0;
      dmem_ready = 1'b1;
      dmem_rdata = 32'hDEAD_BEEF;
      @(negedge clk);
      checks++; if (dmem_req !== 1'b0 || stall_Mem !== 1'b0) begin
         errors++; $display("FAIL rw_idle: got req %b stall %b expected 0 0", dmem_req, stall_Mem); end
      step();
      dmem_ready = 1'b0;
      @(negedge clk);
      checks++; if (readD_Mem_Out !== 32'h0 || busErr_Mem !== 1'b0) begin
         errors++; $display("FAIL rw_late_ready: got readD %h berr %b expected 00000000 0",
                             readD_Mem_Out, busErr_Mem); end
      step();
   endtask

   initial begin
      rst = 1'b1;
      set_idle();
      test_reset();
      test_lb();
      test_passthrough();
      test_stores();
      test_lhu_delay();
      test_timeout();
      test_misaligned();
      test_reset_in_wait();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/memory_access_stage.md
# memory_access_stage

RV32I memory-access (MEM) stage between the EX/MEM and MEM/WB pipeline registers. It takes load/store requests from EX/MEM and runs a req/ready transaction on a word-wide data-memory port. It generates byte enables and lane-replicated store data, then aligns and sign/zero-extends load data. It stalls the pipeline until the access completes and passes the writeback control fields through to MEM/WB.

## Interface
- TIMEOUT_CYCLES, 16: WAIT cycles without dmem_ready before bus error; range 2..255.
- clk  in  1  clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- memRead_Mem_In, memWrite_Mem_In  in  1 each  load / store request from EX/MEM; never both high
- funct3_Mem_In  in  3  access size and sign (RV32I encoding)
- aluOut_Mem_In  in  32  effective byte address / ALU result
- writeData_Mem_In  in  32  store source (rs2)
- regWrite_Mem_In, memToRegWrite_Mem_In  in  1 each  writeback controls
- rd_Mem_In  in  5  destination register
- dmem_req  out  1  access request, held until accepted
- dmem_we  out  1  1 = store
- dmem_addr  out  32  word address, bits [1:0] = 0
- dmem_wdata  out  32  lane-replicated store data
- dmem_be  out  4  byte enables
- dmem_ready  in  1  access complete; dmem_rdata valid in the same cycle
- dmem_rdata  in  32  raw read word
- readD_Mem_Out  out  32  aligned, extended load result to MEM/WB
- aluOut_Mem_Out, rd_Mem_Out, memToRegWrite_Mem_Out  out  32/5/1  pass-through to MEM/WB
- regWrite_Mem_Out  out  1  regWrite_Mem_In gated by error
- stall_Mem  out  1  freeze PC, IF/ID, ID/EX, EX/MEM; MEM/WB must not capture
- busErr_Mem  out  1  one-cycle pulse: access timed out
- misaligned_Mem  out  1  one-cycle pulse: misaligned access (macro-dependent)

## Operation
- FSM states: IDLE, WAIT, DONE.
- IDLE with no access: stall_Mem=0, and the stage is transparent except readD_Mem_Out, which holds the last captured value.
- IDLE with a valid access: dmem_req=1 combinationally, and address, we, be and wdata are registered into holding regs. stall_Mem=1, and the FSM moves to WAIT.
- WAIT: dmem_req=1 and the bus is driven from the holding regs, stable; stall_Mem=1; the timeout counter increments.
  - dmem_ready=1: capture the extended load data (stores capture 0) and go to DONE.
  - Counter reaching TIMEOUT_CYCLES: capture 0, pulse busErr_Mem in DONE, go to DONE.
- DONE: dmem_req=0, stall_Mem=0, and MEM/WB captures this cycle. The next state is always IDLE, so the still-present EX/MEM instruction is never re-issued.
- Loads, by funct3:
  - 000 LB: sign-extend the byte at addr[1:0].
  - 100 LBU: zero-extend the byte at addr[1:0].
  - 001 LH: sign-extend the half at addr[1].
  - 101 LHU: zero-extend the half at addr[1].
  - 010 LW: full word.
  - Other codes: treated as LW.
- Stores:
  - SB: be = 1<<addr[1:0], wdata = {4{wd[7:0]}}.
  - SH: be = addr[1] ? 1100 : 0011, wdata = {2{wd[15:0]}}.
  - SW: be = 1111.
  - For loads, be = 1111.
- regWrite_Mem_Out = regWrite_Mem_In & ~(busErr_Mem | misaligned_Mem).
- dmem_ready outside WAIT is ignored.

## Timing
- Memory op minimum: request at cycle 0, ready at cycle 1 (WAIT), DONE at cycle 2. That is 2 stall cycles, plus 1 per extra ready delay.
- Non-memory instructions: 0 stall, combinational pass-through.
- Reset values: state IDLE, counter 0, readD_Mem_Out 0, dmem_req 0, dmem_we 0, dmem_be 0, dmem_addr 0, dmem_wdata 0, stall_Mem 0, busErr_Mem 0, misaligned_Mem 0.
- Reset in WAIT: the next edge gives IDLE with dmem_req=0, and any later ready is ignored.
- Timeout: busErr_Mem pulses in DONE after exactly TIMEOUT_CYCLES WAIT cycles.

## Configuration
- DMEM_MISALIGN_CHECK_EN defined: a halfword with addr[0]=1 or a word with addr[1:0]!=0 issues no request. The FSM goes IDLE to DONE (1 stall cycle), with misaligned_Mem=1 and regWrite_Mem_Out=0 in DONE, and readD 0.
- DMEM_MISALIGN_CHECK_EN undefined: misaligned_Mem is tied 0. The offending low address bits are masked (word gets [1:0]=0, half gets [0]=0) and the access proceeds normally.

## Test plan
- LB at 0x103, rdata 0x80AABBCC, ready after 1 cycle: expect be=1111, dmem_addr=0x100, readD=0xFFFFFF80, and exactly 2 stall cycles.
- SH at 0x22, wd=0x1234ABCD: expect be=1100, wdata=0xABCDABCD, dmem_we=1, regWrite_Mem_Out passes through.
- LHU at 0x2, ready delayed 4 cycles, rdata 0xF00D0000: expect req held stable for 5 cycles, readD=0x0000F00D, and stall high for 5 cycles.
- LW with ready never asserted, TIMEOUT_CYCLES=16: expect a busErr_Mem pulse after 16 WAIT cycles, readD=0, and regWrite_Mem_Out=0 in DONE.
- LW at 0x6: with the macro, expect no dmem_req, misaligned_Mem pulse, and 1 stall. Without the macro, expect dmem_addr=0x4 and a normal load.
- rst asserted in WAIT, then a late dmem_ready: expect IDLE, req=0, and readD unchanged at 0.
